serial_addsub_ctrl: RTL and testbench
=====================================

Name: serial_addsub_ctrl

Overview:
Bit-serial adder/subtractor sequencer. Accepts one operand pair and an add/sub select over a valid/ready handshake. It then drives a single one-bit full-adder cell (two halfadder instances plus an OR) for WIDTH cycles, LSB first, and returns the result over a second valid/ready handshake. This is the area-minimal alternative to the parallel adder-subtractor, used where throughput is not critical.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock; sole clock.
rst_n  input  1  reset; synchronous, active-low.
in_valid  input  1  operand pair presented.
in_ready  output  1  block can accept an operand pair.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
sub  input  1  0 = A+B, 1 = A-B.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  result (A+B or A-B, modulo 2^WIDTH).
cout  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned).
ovf  output  1  two's-complement signed overflow.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: clk and rst_n only; rst_n sampled at the rising edge of clk.
  - Outputs after any edge with rst_n=0: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - Reset mid-RUN or mid-DONE aborts the operation. The result is discarded and never presented.
- States: IDLE, RUN, DONE.
- IDLE
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, the operation is accepted:
    - opA_sr <= a
    - opB_sr <= b XOR {WIDTH{sub}}
    - carry <= sub
    - bitcnt <= 0
    - state <= RUN
  - in_valid=0: remain in IDLE.
- RUN
  - in_ready=0, out_valid=0, busy=1.
  - Each edge:
    - The cell computes s = opA_sr[0] ^ opB_sr[0] ^ carry and c = majority of the same three bits.
    - res_sr <= {s, res_sr[WIDTH-1:1]}.
    - opA_sr and opB_sr shift right by 1.
    - carry <= c.
    - bitcnt increments.
  - On the edge processing bit WIDTH-1:
    - ovf <= carry_in XOR c, where carry_in is the carry into that bit.
    - cout <= c.
    - sum is loaded from the completed shift register.
    - state <= DONE.
  - Inputs are ignored in RUN.
- DONE
  - out_valid=1, in_ready=0; sum, cout and ovf are held stable.
  - On an edge with out_ready=1: out_valid drops, state <= IDLE.
  - out_ready=0: hold indefinitely.
  - sum, cout and ovf keep their last values in IDLE until the next operation completes.
- Latency:
  - out_valid rises exactly WIDTH edges after the accept edge.
  - Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH bits, one DONE cycle with immediate out_ready.
- Handshakes:
  - A transfer occurs only on an edge where valid and ready are both 1.
  - in_ready depends on state only and has no combinational path from in_valid.
  - out_valid is registered.
- Simultaneous in_valid=1 while DONE: not accepted. The new pair must be re-presented in IDLE.
- The bit counter width is clog2(WIDTH+1). It must not wrap during RUN.

Decomposition:
- Package serial_addsub_pkg contains:
  - the state enum (IDLE, RUN, DONE), 2 bits;
  - the count-width function/constant.
- One sub-module: serial_fa_cell. It is a combinational 1-bit full adder built from two halfadder instances, with carry = c1 | c2. The controller owns all flops.

Test Plan:
- WIDTH=8, add 0x5A + 0x3C -> sum=0x96, cout=0, ovf=1; out_valid exactly 8 cycles after the accept edge.
- Add 0xFF + 0x01 -> sum=0x00, cout=1, ovf=0.
- Sub 0x10 - 0x20 -> sum=0xF0, cout=0 (borrow), ovf=0.
- Sub 0x80 - 0x01 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Required: sum, cout and ovf stable; in_ready=0; a new in_valid pulse is ignored.
  - Release out_ready: IDLE on the next cycle.
  - Next op 0x01+0x01 -> sum=0x02.
- Reset: rst_n=0 for one edge at RUN bit 3.
  - Required: next cycle IDLE, in_ready=1, out_valid=0, outputs 0.
  - No out_valid pulse follows.
  - Subsequent 0x03+0x04 -> sum=0x07.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit counter must be able to hold the value `w` itself so it never wraps mid-run.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/halfadder.sv
// One-bit half adder.
module halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_addsub_ctrl_fa_cell.sv
// Combinational one-bit full adder built from two half adders.
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic s1;
  logic c1;
  logic c2;

  halfadder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s1),
    .c_o (c1)
  );

  halfadder u_ha1 (
    .a_i (s1),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (c2)
  );

  assign c_o = c1 | c2;

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor sequencer: accepts an operand pair, runs one full-adder
// cell LSB first for WIDTH cycles, then holds the result until the consumer takes it.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic cell_s;
  logic cell_c;

  serial_fa_cell u_cell (
    .a_i (opa_q[0]),
    .b_i (opb_q[0]),
    .c_i (carry_q),
    .s_o (cell_s),
    .c_o (cell_c)
  );

  // Next-state and datapath update for the three-phase sequencer.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d   = {cell_s, res_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = cell_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          sum_d   = {cell_s, res_q[WIDTH-1:1]};
          cout_d  = cell_c;
          ovf_d   = carry_q ^ cell_c;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    out_valid_d = (state_d == StDone);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      opa_q       <= '0;
      opb_q       <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench: a cycle-level behavioural model (latency counter plus arithmetic
// result) is compared against the DUT every cycle, with literal checks on directed cases.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  serial_addsub_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Arithmetic reference from plain integer math.
  function automatic void ref_calc(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input bit ts, output logic [W-1:0] rs,
                                   output bit rc, output bit ro);
    longint ua, ub, sa, sb, r, u;
    ua = longint'(ta);
    ub = longint'(tb);
    sa = (ta[W-1]) ? ua - (longint'(1) << W) : ua;
    sb = (tb[W-1]) ? ub - (longint'(1) << W) : ub;
    if (ts) begin
      u  = ua - ub;
      r  = sa - sb;
      rc = (ua >= ub);
    end else begin
      u  = ua + ub;
      r  = sa + sb;
      rc = (u >= (longint'(1) << W));
    end
    rs = W'(u);
    ro = (r > (longint'(1) << (W - 1)) - 1) || (r < -(longint'(1) << (W - 1)));
  endfunction

  // Model state: idle flag, cycles remaining until result, pending and visible results.
  bit           m_idle = 1'b1;
  bit           m_valid = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_sum = '0, p_sum = '0;
  bit           m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;
  bit           started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idle  = 1'b1;
      m_valid = 1'b0;
      m_left  = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_idle) begin
      if (in_valid) begin
        ref_calc(a, b, sub, p_sum, p_cout, p_ovf);
        m_idle = 1'b0;
        m_left = W;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1;
        m_sum   = p_sum;
        m_cout  = p_cout;
        m_ovf   = p_ovf;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
      m_idle  = 1'b1;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, m_idle);
      chk("out_valid", out_valid, m_valid);
      chk("busy", busy, !m_idle);
      chk("sum", sum, m_sum);
      chk("cout", cout, m_cout);
      chk("ovf", ovf, m_ovf);
    end
  end

  // One operation: accept, wait for result, hold for `hold` cycles, then release.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit ts,
                        input int hold, input bit junk);
    int lat;
    @(negedge clk);
    a = ta;
    b = tb;
    sub = ts;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      if (junk) in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, W);
    repeat (hold) begin
      if (junk) in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_release", in_ready, 1'b1);
  endtask

  initial begin
    int pulses;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);

    run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    chk("5a+3c sum", sum, 8'h96);
    chk("5a+3c cout", cout, 1'b0);
    chk("5a+3c ovf", ovf, 1'b1);

    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    chk("ff+01 sum", sum, 8'h00);
    chk("ff+01 cout", cout, 1'b1);
    chk("ff+01 ovf", ovf, 1'b0);

    run_op(8'h10, 8'h20, 1'b1, 0, 1'b0);
    chk("10-20 sum", sum, 8'hF0);
    chk("10-20 cout", cout, 1'b0);
    chk("10-20 ovf", ovf, 1'b0);

    run_op(8'h80, 8'h01, 1'b1, 5, 1'b1);
    chk("80-01 sum", sum, 8'h7F);
    chk("80-01 cout", cout, 1'b1);
    chk("80-01 ovf", ovf, 1'b1);

    run_op(8'h01, 8'h01, 1'b0, 0, 1'b0);
    chk("01+01 sum", sum, 8'h02);

    // Abort mid-run with a single reset edge after three bits have been processed.
    @(negedge clk);
    a = 8'h11;
    b = 8'h22;
    sub = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort in_ready", in_ready, 1'b1);
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort sum", sum, 8'h00);
    chk("abort cout", cout, 1'b0);
    chk("abort ovf", ovf, 1'b0);
    pulses = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("abort no result", pulses, 0);

    run_op(8'h03, 8'h04, 1'b0, 0, 1'b0);
    chk("03+04 sum", sum, 8'h07);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
